// File: rtl/rv_defs.sv
// Shared RISC-V decode definitions: base opcodes, immediate-type codes and an XLEN legality check.
package rv_defs;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef enum logic [2:0] {
    IMM_U   = 3'd0,
    IMM_J   = 3'd1,
    IMM_I   = 3'd2,
    IMM_S   = 3'd3,
    IMM_B   = 3'd4,
    IMM_R   = 3'd5,
    IMM_Z   = 3'd6,
    IMM_ILL = 3'd7
  } imm_type_e;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/rv_skid_buffer.sv
// Valid/ready pipeline register with a one-deep skid slot; in_ready is registered (!skid_valid).
module rv_skid_buffer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         in_ready_q, in_ready_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         accept;
  logic         main_free;

  always_comb begin
    accept       = in_valid & in_ready_q;
    main_free    = ~main_valid_q | out_ready;
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    // accept implies skid empty, so the skid-refill and direct-load branches never collide
    if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

endmodule

// File: rtl/rv_imm_decode_stage.sv
// Opcode-driven immediate decode in front of a skid-buffered pipeline register.
// Optional: RV_IMM_ZICSR_EN decodes CSR*I encodings as type Z (zero-extended uimm).
module rv_imm_decode_stage
  import rv_defs::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam int unsigned PW = 2 * XLEN + 4;

  if (!xlen_legal(XLEN) || (PC_W > XLEN)) begin : g_bad_cfg
    $error("rv_imm_decode_stage: XLEN must be 32 or 64 and PC_W <= XLEN");
  end

  logic [6:0]         opcode;
  imm_type_e          dec_type;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]    dec_imm;
  logic [XLEN-1:0]    dec_target;
  logic [PW-1:0]      in_data;
  logic [PW-1:0]      out_data;

  always_comb begin
    opcode   = in_inst[6:0];
    dec_type = IMM_ILL;
    case (opcode)
      OPC_LUI, OPC_AUIPC:                         dec_type = IMM_U;
      OPC_JAL:                                    dec_type = IMM_J;
      OPC_BRANCH:                                 dec_type = IMM_B;
      OPC_STORE:                                  dec_type = IMM_S;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM: dec_type = IMM_I;
      OPC_SYSTEM: begin
`ifdef RV_IMM_ZICSR_EN
        dec_type = in_inst[14] ? IMM_Z : IMM_I;
`else
        dec_type = IMM_I;
`endif
      end
      OPC_OP:        dec_type = IMM_R;
      OPC_OP_IMM_32: dec_type = (XLEN == 64) ? IMM_I : IMM_ILL;
      OPC_OP_32:     dec_type = (XLEN == 64) ? IMM_R : IMM_ILL;
      default:       dec_type = IMM_ILL;
    endcase

    // every format fits in 32 bits; the signed cast below widens to XLEN
    imm32 = '0;
    case (dec_type)
      IMM_U: imm32 = {in_inst[31:12], 12'b0};
      IMM_J: imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      IMM_I: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      IMM_S: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      IMM_B: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                      in_inst[11:8], 1'b0};
      IMM_Z: imm32 = {27'b0, in_inst[19:15]};
      default: imm32 = '0;
    endcase
    dec_imm = XLEN'(imm32);

    if ((dec_type == IMM_J) || (dec_type == IMM_B) || (opcode == OPC_AUIPC)) begin
      dec_target = XLEN'(in_pc) + dec_imm;
    end else begin
      dec_target = '0;
    end

    in_data = {(dec_type == IMM_ILL), dec_type, dec_imm, dec_target};
  end

  rv_skid_buffer #(
    .W(PW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  assign {out_illegal, out_type, out_imm, out_target} = out_data;

endmodule
